biu_line_arbiter: RTL and testbench

- Shares the BIU cache-line request/response port among NUM_REQ line requesters: requester 0 = I-cache, 1 = D-cache, 2 = PTW.
- Round-robin arbitration; one outstanding transaction at a time, locked to its owner until the response is consumed.
- Routes the response back to the owner.
- A watchdog converts a hung BIU transaction into an error response, then absorbs the late BIU response.

---
 rtl/biu_line_arbiter.sv | 175 +++++++++++++++++
 tb/tb_biu_line_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biu_line_arbiter.sv
// biu_line_arbiter: shares one BIU cache-line request/response port among
// NUM_REQ requesters (0 = I-cache, 1 = D-cache, 2 = PTW). Round-robin grant,
// one transaction in flight, locked to its owner until the response is
// consumed. A watchdog turns a hung BIU transaction into an error response
// and then swallows the late BIU response.
//
// Handshake semantics (all ports): a transfer happens in a cycle where both
// valid and ready are high at the rising clock edge. A valid, once raised, is
// held with a stable payload until the transfer; ready may depend
// combinationally on valid (req_rdy_o does).
module biu_line_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 64,
    parameter int LINE_W      = 512,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_vld_i,
    output logic [NUM_REQ-1:0]        req_rdy_o,
    input  logic [NUM_REQ-1:0]        req_rd_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*LINE_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        resp_vld_o,
    input  logic [NUM_REQ-1:0]        resp_rdy_i,
    output logic [LINE_W-1:0]         resp_rdata_o,
    output logic                      resp_err_o,
    output logic                      biu_req_vld_o,
    input  logic                      biu_req_rdy_i,
    output logic                      biu_req_rd_o,
    output logic [ADDR_W-1:0]         biu_req_addr_o,
    output logic [LINE_W-1:0]         biu_req_wdata_o,
    input  logic                      biu_resp_vld_i,
    output logic                      biu_resp_rdy_o,
    input  logic [LINE_W-1:0]         biu_resp_rdata_i,
    input  logic                      biu_resp_err_i
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int WDOG_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_REQ - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic [2:0]        state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  owner;
    logic [WDOG_W-1:0] wdog;
    logic              drain_pending;

    logic              grant_found;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W:0]    cand_sum;
    logic [PTR_W-1:0]  cand_idx;
    logic              accept;
    logic              misaligned;
    int                addr_base;
    int                line_base;

    // Round-robin search: first valid requester starting at rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (cand_sum >= (PTR_W+1)'(NUM_REQ)) begin
                cand_idx = PTR_W'(cand_sum - (PTR_W+1)'(NUM_REQ));
            end else begin
                cand_idx = PTR_W'(cand_sum);
            end
            if (!grant_found && req_vld_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Slice offsets of the granted requester inside the flattened buses.
    always_comb begin
        addr_base = int'(grant_idx) * ADDR_W;
        line_base = int'(grant_idx) * LINE_W;
    end

    assign accept     = (state == ST_IDLE) && grant_found;
    assign misaligned = (req_addr_i[addr_base +: 6] != 6'd0);

    assign req_rdy_o      = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    assign resp_vld_o     = (state == ST_RESP) ? (NUM_REQ'(1) << owner) : '0;
    assign biu_req_vld_o  = (state == ST_ISSUE);
    assign biu_resp_rdy_o = (state == ST_WAIT) || (state == ST_DRAIN);

    // Transaction FSM, arbitration pointer, watchdog and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            wdog          <= '0;
            drain_pending <= 1'b0;
            resp_rdata_o  <= '0;
            resp_err_o    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        owner  <= grant_idx;
                        rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                        if (misaligned) begin
                            // Misaligned lines never reach the BIU.
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
                            state        <= ST_RESP;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (biu_req_rdy_i) begin
                        wdog  <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wdog <= wdog + 1'b1;
                    // A real response wins over a coincident timeout.
                    if (biu_resp_vld_i) begin
                        resp_rdata_o <= biu_resp_rdata_i;
                        resp_err_o   <= biu_resp_err_i;
                        state        <= ST_RESP;
                    end else if (wdog == WDOG_LAST) begin
                        resp_rdata_o  <= '0;
                        resp_err_o    <= 1'b1;
                        drain_pending <= 1'b1;
                        state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_rdy_i[owner]) begin
                        state <= drain_pending ? ST_DRAIN : ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    // Late BIU response for a timed-out request is discarded.
                    if (biu_resp_vld_i) begin
                        drain_pending <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Request payload captured at acceptance and held for the BIU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            biu_req_rd_o    <= 1'b0;
            biu_req_addr_o  <= '0;
            biu_req_wdata_o <= '0;
        end else if (accept) begin
            biu_req_rd_o    <= req_rd_i[grant_idx];
            biu_req_addr_o  <= req_addr_i[addr_base +: ADDR_W];
            biu_req_wdata_o <= req_wdata_i[line_base +: LINE_W];
        end
    end

endmodule

// File: tb/tb_biu_line_arbiter.sv
// Testbench for biu_line_arbiter: random and directed line transactions
// checked against a transaction-level reference model.
module tb_biu_line_arbiter;

    localparam int NUM_REQ     = 3;
    localparam int ADDR_W      = 64;
    localparam int LINE_W      = 512;
    localparam int TIMEOUT_CYC = 8;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_vld_i;
    logic [NUM_REQ-1:0]        req_rdy_o;
    logic [NUM_REQ-1:0]        req_rd_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*LINE_W-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]        resp_vld_o;
    logic [NUM_REQ-1:0]        resp_rdy_i;
    logic [LINE_W-1:0]         resp_rdata_o;
    logic                      resp_err_o;
    logic                      biu_req_vld_o;
    logic                      biu_req_rdy_i;
    logic                      biu_req_rd_o;
    logic [ADDR_W-1:0]         biu_req_addr_o;
    logic [LINE_W-1:0]         biu_req_wdata_o;
    logic                      biu_resp_vld_i;
    logic                      biu_resp_rdy_o;
    logic [LINE_W-1:0]         biu_resp_rdata_i;
    logic                      biu_resp_err_i;

    biu_line_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_W     (ADDR_W),
        .LINE_W     (LINE_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_vld_i       (req_vld_i),
        .req_rdy_o       (req_rdy_o),
        .req_rd_i        (req_rd_i),
        .req_addr_i      (req_addr_i),
        .req_wdata_i     (req_wdata_i),
        .resp_vld_o      (resp_vld_o),
        .resp_rdy_i      (resp_rdy_i),
        .resp_rdata_o    (resp_rdata_o),
        .resp_err_o      (resp_err_o),
        .biu_req_vld_o   (biu_req_vld_o),
        .biu_req_rdy_i   (biu_req_rdy_i),
        .biu_req_rd_o    (biu_req_rd_o),
        .biu_req_addr_o  (biu_req_addr_o),
        .biu_req_wdata_o (biu_req_wdata_o),
        .biu_resp_vld_i  (biu_resp_vld_i),
        .biu_resp_rdy_o  (biu_resp_rdy_o),
        .biu_resp_rdata_i(biu_resp_rdata_i),
        .biu_resp_err_i  (biu_resp_err_i)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int model_rr = 0;
    logic [LINE_W:0] exp_q[$];   // {err, rdata} of each expected response

    logic [ADDR_W-1:0] p_addr  [NUM_REQ];
    logic [LINE_W-1:0] p_wdata [NUM_REQ];
    logic [NUM_REQ-1:0] p_rd;

    task automatic check(input string tag, input logic [LINE_W-1:0] got,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W/32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int g);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    // Reference arbitration: first requesting index scanning from the pointer.
    function automatic int pick_grant(input logic [NUM_REQ-1:0] mask);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask[(model_rr + i) % NUM_REQ]) return (model_rr + i) % NUM_REQ;
        end
        return 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load_payloads(input int mis_pct);
        for (int i = 0; i < NUM_REQ; i++) begin
            p_addr[i] = {$urandom(), $urandom()} & ~64'h3f;
            if ($urandom_range(0, 99) < mis_pct) p_addr[i][5:0] = 6'($urandom_range(1, 63));
            p_rd[i]    = 1'($urandom_range(0, 1));
            p_wdata[i] = rand_line();
        end
    endtask

    task automatic pack();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr_i[i*ADDR_W +: ADDR_W]  = p_addr[i];
            req_wdata_i[i*LINE_W +: LINE_W] = p_wdata[i];
        end
        req_rd_i = p_rd;
    endtask

    // One cycle window: inputs change just after the falling edge, outputs
    // are sampled 1 ns later, the rising edge closes the window.
    task automatic window();
        @(negedge clk);
        biu_req_rdy_i  = 1'b0;
        biu_resp_vld_i = 1'b0;
        resp_rdy_i     = '0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_rdy"}, req_rdy_o, 0);
        check({tag, "_resp_vld"}, resp_vld_o, 0);
        check({tag, "_resp_err"}, resp_err_o, 0);
        check({tag, "_resp_rdata"}, resp_rdata_o, 0);
        check({tag, "_biu_req_vld"}, biu_req_vld_o, 0);
        check({tag, "_biu_resp_rdy"}, biu_resp_rdy_o, 0);
        check({tag, "_biu_rd"}, biu_req_rd_o, 0);
        check({tag, "_biu_addr"}, biu_req_addr_o, 0);
        check({tag, "_biu_wdata"}, biu_req_wdata_o, 0);
    endtask

    // Full transaction; payloads in p_* must be set by the caller.
    task automatic run_txn(input logic [NUM_REQ-1:0] mask, input int req_wait,
                           input int resp_dly, input bit hang, input int hold,
                           input int drain_dly, input logic [LINE_W-1:0] line,
                           input logic err);
        int g;
        logic [ADDR_W-1:0] e_addr;
        logic [LINE_W-1:0] e_wdata;
        logic e_rd;
        logic [LINE_W:0] e;
        // acceptance
        window();
        pack();
        req_vld_i = mask;
        #1;
        g = pick_grant(mask);
        check("idle_req_rdy", req_rdy_o, onehot(g));
        check("idle_biu_req_vld", biu_req_vld_o, 0);
        check("idle_resp_vld", resp_vld_o, 0);
        e_addr   = p_addr[g];
        e_wdata  = p_wdata[g];
        e_rd     = p_rd[g];
        model_rr = (g + 1) % NUM_REQ;
        if (e_addr[5:0] != 6'd0) begin
            e = '0;
            e[LINE_W] = 1'b1;
            exp_q.push_back(e);
        end else begin
            for (int i = 0; i <= req_wait; i++) begin
                window();
                load_payloads(50);
                pack();
                if (i == req_wait) biu_req_rdy_i = 1'b1;
                #1;
                check("issue_vld", biu_req_vld_o, 1);
                check("issue_addr", biu_req_addr_o, e_addr);
                check("issue_rd", biu_req_rd_o, e_rd);
                check("issue_wdata", biu_req_wdata_o, e_wdata);
                check("issue_req_rdy", req_rdy_o, 0);
                check("issue_biu_resp_rdy", biu_resp_rdy_o, 0);
            end
            if (hang) begin
                for (int i = 0; i < TIMEOUT_CYC; i++) begin
                    window();
                    #1;
                    check("wdog_biu_resp_rdy", biu_resp_rdy_o, 1);
                    check("wdog_resp_vld", resp_vld_o, 0);
                    check("wdog_biu_req_vld", biu_req_vld_o, 0);
                    check("wdog_req_rdy", req_rdy_o, 0);
                end
                e = '0;
                e[LINE_W] = 1'b1;
                exp_q.push_back(e);
            end else begin
                for (int i = 0; i <= resp_dly; i++) begin
                    window();
                    if (i == resp_dly) begin
                        biu_resp_vld_i   = 1'b1;
                        biu_resp_rdata_i = line;
                        biu_resp_err_i   = err;
                    end else begin
                        biu_resp_rdata_i = rand_line();
                        biu_resp_err_i   = 1'($urandom_range(0, 1));
                    end
                    #1;
                    check("wait_biu_resp_rdy", biu_resp_rdy_o, 1);
                    check("wait_resp_vld", resp_vld_o, 0);
                    check("wait_biu_req_vld", biu_req_vld_o, 0);
                end
                exp_q.push_back({err, line});
            end
        end
        // response delivery to the owner
        e = exp_q.pop_front();
        for (int i = 0; i <= hold; i++) begin
            window();
            resp_rdy_i = NUM_REQ'($urandom()) & ~onehot(g);
            if (i == hold) resp_rdy_i[g] = 1'b1;
            #1;
            check("resp_vld", resp_vld_o, onehot(g));
            check("resp_err", resp_err_o, e[LINE_W]);
            check("resp_rdata", resp_rdata_o, e[LINE_W-1:0]);
            check("resp_biu_resp_rdy", biu_resp_rdy_o, 0);
            check("resp_req_rdy", req_rdy_o, 0);
            check("resp_biu_req_vld", biu_req_vld_o, 0);
        end
        // late BIU response after a timeout is swallowed
        if (hang) begin
            for (int i = 0; i <= drain_dly; i++) begin
                window();
                if (i == drain_dly) begin
                    biu_resp_vld_i   = 1'b1;
                    biu_resp_rdata_i = rand_line();
                end
                #1;
                check("drain_biu_resp_rdy", biu_resp_rdy_o, 1);
                check("drain_resp_vld", resp_vld_o, 0);
                check("drain_req_rdy", req_rdy_o, 0);
            end
        end
    endtask

    // Reset asserted while a transaction waits for the BIU.
    task automatic reset_in_wait();
        int g;
        window();
        load_payloads(0);
        pack();
        req_vld_i = 3'b100;
        #1;
        g = pick_grant(3'b100);
        check("rw_req_rdy", req_rdy_o, onehot(g));
        model_rr = (g + 1) % NUM_REQ;
        window();
        biu_req_rdy_i = 1'b1;
        #1;
        check("rw_issue_vld", biu_req_vld_o, 1);
        window();
        #1;
        check("rw_wait_rdy", biu_resp_rdy_o, 1);
        #2;
        rst_n     = 1'b0;
        req_vld_i = '0;
        #1;
        check_reset("rw");
        window();
        window();
        rst_n    = 1'b1;
        model_rr = 0;
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n            = 1'b0;
        req_vld_i        = '0;
        req_rd_i         = '0;
        req_addr_i       = '0;
        req_wdata_i      = '0;
        resp_rdy_i       = '0;
        biu_req_rdy_i    = 1'b0;
        biu_resp_vld_i   = 1'b0;
        biu_resp_rdata_i = '0;
        biu_resp_err_i   = 1'b0;
        repeat (2) window();
        #1;
        check_reset("por");
        window();
        rst_n = 1'b1;

        // round robin with all three requesters continuously valid
        for (int k = 0; k < 4; k++) begin
            load_payloads(0);
            run_txn(3'b111, $urandom_range(0, 2), $urandom_range(0, TIMEOUT_CYC-1), 1'b0,
                    $urandom_range(0, 2), 0, rand_line(), 1'b0);
        end

        // single D-cache read with 0xA5 line
        load_payloads(0);
        p_addr[1] = 64'h0000_0000_8000_0040;
        p_rd[1]   = 1'b1;
        run_txn(3'b010, 0, 3, 1'b0, 0, 0, {64{8'hA5}}, 1'b0);

        // response backpressure with other requesters waiting
        load_payloads(0);
        run_txn(3'b110, 1, 2, 1'b0, 5, 0, rand_line(), 1'b1);

        // misaligned request never reaches the BIU
        load_payloads(0);
        p_addr[0] = 64'h1004;
        run_txn(3'b001, 0, 0, 1'b0, 1, 0, '0, 1'b0);

        // watchdog, then a normal transaction
        load_payloads(0);
        run_txn(3'b001, 0, 0, 1'b1, 1, 3, '0, 1'b0);
        load_payloads(0);
        run_txn(3'b001, 0, 2, 1'b0, 0, 0, rand_line(), 1'b0);

        // response coinciding with the timeout wins
        load_payloads(0);
        run_txn(3'b100, 0, TIMEOUT_CYC-1, 1'b0, 0, 0, rand_line(), 1'b0);

        // randomized traffic with idle gaps
        for (int k = 0; k < 40; k++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int j = 0; j < gap; j++) begin
                window();
                req_vld_i = '0;
                #1;
                check("gap_req_rdy", req_rdy_o, 0);
            end
            load_payloads(25);
            run_txn(NUM_REQ'($urandom_range(1, 7)), $urandom_range(0, 2),
                    $urandom_range(0, TIMEOUT_CYC-1), ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 3), $urandom_range(0, 3), rand_line(),
                    ($urandom_range(0, 7) == 0));
        end

        // asynchronous reset in the wait state, then requester 0 wins
        reset_in_wait();
        load_payloads(0);
        run_txn(3'b111, 0, 1, 1'b0, 0, 0, rand_line(), 1'b0);

        window();
        req_vld_i = '0;
        #1;
        check("final_scoreboard_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
